// File: rtl/ad_serial_pkg.sv
// rtl/ad_serial_pkg.sv - shared state encoding and default sizes for the AD serial path
package ad_serial_pkg;
  localparam int DEFAULT_DW          = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BUS = 2'd1,
    SHIFT    = 2'd2,
    PARITY   = 2'd3
  } state_t;
endpackage

// File: rtl/ad_sync_edge.sv
// rtl/ad_sync_edge.sv - multi-stage input synchroniser with falling-edge detect
module ad_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  // prev_q holds the previous synchronised level, so a held-low input yields one edge only
  assign fall_o  = prev_q & ~sync_q[STAGES-1];
endmodule

// File: rtl/ad_serial_sequencer.sv
// rtl/ad_serial_sequencer.sv - samples the AD bus in its valid window and shifts it out MSB first
// Defining AD_SERIAL_PARITY_EN appends one even-parity bit to every frame.
module ad_serial_sequencer
  import ad_serial_pkg::*;
#(
  parameter int DW          = DEFAULT_DW,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int SAMPLE_DLY  = 1,
  parameter int BUS_TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          nGet_AD_data,
  input  logic          use_p_in_bus,
  input  logic [DW-1:0] databus,
  output logic          Dbit_out,
  output logic          Dbit_ena,
  output logic          busy,
  output logic          overrun,
  output logic          bus_timeout
);
  localparam int TW = $clog2(BUS_TIMEOUT + 1);
  localparam int CW = $clog2(DW + 1);

  state_t        state_q;
  logic [2:0]    win_q;
  logic [TW-1:0] tmo_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] sreg_q;
  logic          dout_q, dena_q, ovr_q, btmo_q;
`ifdef AD_SERIAL_PARITY_EN
  logic          par_q;
`endif
  logic          req, bus_lvl, capture;
  logic          nget_lvl_unused, bus_fall_unused;

  ad_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_nget_sync (
    .clk(clk), .rst(rst), .d_i(nGet_AD_data), .level_o(nget_lvl_unused), .fall_o(req)
  );

  ad_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_bus_sync (
    .clk(clk), .rst(rst), .d_i(use_p_in_bus), .level_o(bus_lvl), .fall_o(bus_fall_unused)
  );

  assign capture = bus_lvl && (win_q == 3'(SAMPLE_DLY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      sreg_q  <= '0;
      dout_q  <= 1'b0;
      dena_q  <= 1'b0;
      ovr_q   <= 1'b0;
      btmo_q  <= 1'b0;
`ifdef AD_SERIAL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      ovr_q  <= req && (state_q != IDLE);
      btmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          dout_q <= 1'b0;
          dena_q <= 1'b0;
          if (req) begin
            state_q <= WAIT_BUS;
            tmo_q   <= '0;
            win_q   <= '0;
          end
        end
        WAIT_BUS: begin
          // capture outranks timeout; the MSB goes straight to the output register
          if (capture) begin
            state_q <= SHIFT;
            sreg_q  <= {databus[DW-2:0], 1'b0};
            dout_q  <= databus[DW-1];
            dena_q  <= 1'b1;
            cnt_q   <= CW'(1);
`ifdef AD_SERIAL_PARITY_EN
            par_q   <= ^databus;
`endif
          end else if (tmo_q == TW'(BUS_TIMEOUT - 1)) begin
            state_q <= IDLE;
            btmo_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            win_q <= bus_lvl ? win_q + 1'b1 : 3'd0;
          end
        end
        SHIFT: begin
          if (cnt_q == CW'(DW)) begin
`ifdef AD_SERIAL_PARITY_EN
            state_q <= PARITY;
            dout_q  <= par_q;
            dena_q  <= 1'b1;
`else
            state_q <= IDLE;
            dout_q  <= 1'b0;
            dena_q  <= 1'b0;
`endif
          end else begin
            dout_q <= sreg_q[DW-1];
            sreg_q <= sreg_q << 1;
            cnt_q  <= cnt_q + 1'b1;
          end
        end
`ifdef AD_SERIAL_PARITY_EN
        PARITY: begin
          state_q <= IDLE;
          dout_q  <= 1'b0;
          dena_q  <= 1'b0;
        end
`endif
        default: begin
          state_q <= IDLE;
          dout_q  <= 1'b0;
          dena_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Dbit_out    = dout_q;
  assign Dbit_ena    = dena_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = ovr_q;
  assign bus_timeout = btmo_q;
endmodule

// File: tb/tb_ad_serial_sequencer.sv
// tb/tb_ad_serial_sequencer.sv - scoreboard bench for ad_serial_sequencer
module tb_ad_serial_sequencer;
  localparam int DW  = 8;
  localparam int SD  = 2;
  localparam int TMO = 32;
`ifdef AD_SERIAL_PARITY_EN
  localparam int FRAME_LEN = DW + 1;
`else
  localparam int FRAME_LEN = DW;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          nget = 1'b1;
  logic          usep = 1'b0;
  logic [DW-1:0] databus = 8'h99;
  logic          dout, dena, busy, ovr, btmo;

  ad_serial_sequencer #(.DW(DW), .SYNC_STAGES(2), .SAMPLE_DLY(SD), .BUS_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .nGet_AD_data(nget), .use_p_in_bus(usep), .databus(databus),
    .Dbit_out(dout), .Dbit_ena(dena), .busy(busy), .overrun(ovr), .bus_timeout(btmo)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   bits_seen = 0;
  int   ovr_seen = 0;
  int   tmo_seen = 0;
  logic exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever a serial bit is presented
  always @(negedge clk) begin
    if (!rst) begin
      if (ovr) ovr_seen++;
      if (btmo) tmo_seen++;
      if (dena) begin
        bits_seen++;
        check("bit_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("serial_bit", dout, exp_q.pop_front());
      end
    end
  end

  task automatic push_frame(input logic [DW-1:0] d);
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef AD_SERIAL_PARITY_EN
    exp_q.push_back(^d);
`endif
  endtask

  task automatic wait_busy(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_frame(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic change);
    logic ok;
    databus = d0;
    push_frame(change ? d1 : d0);
    @(posedge clk); #1 nget = 1'b0;
    wait_busy(ok);
    check("request_busy", ok, 1);
    @(posedge clk);
    @(posedge clk); #1 usep = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 3 && !change) usep = 1'b0;
      if (c == 4 && change) databus = d1;
    end
    usep = 1'b0;
    nget = 1'b1;
  endtask

  task automatic finish_frame(input string name, input int b0);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_drained"}, ok, 1);
    if (!ok) exp_q.delete();
    @(negedge clk);
    check({name, "_ena_low"}, dena, 0);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_bit_count"}, bits_seen - b0, FRAME_LEN);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int   b0, b1, o0, t0, n;
    logic ok;

    #1;
    check("reset_dout", dout, 0);
    check("reset_dena", dena, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", ovr, 0);
    check("reset_timeout", btmo, 0);
    repeat (3) @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    b0 = bits_seen; start_frame(8'h99, 8'h99, 1'b0); finish_frame("basic_99", b0);
    b0 = bits_seen; start_frame(8'h9B, 8'h9B, 1'b0); finish_frame("basic_9b", b0);
    b0 = bits_seen; start_frame(8'h3C, 8'h3C, 1'b0); finish_frame("basic_3c", b0);
    b0 = bits_seen; start_frame(8'h99, 8'h9A, 1'b1); finish_frame("offset_9a", b0);

    b0 = bits_seen; t0 = tmo_seen;
    @(posedge clk); #1 nget = 1'b0;
    wait_busy(ok);
    check("timeout_busy", ok, 1);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (btmo) begin
        n = i;
        break;
      end
    end
    check("timeout_latency", n, TMO);
    repeat (30) @(negedge clk); #1;
    check("timeout_single_pulse", tmo_seen - t0, 1);
    check("timeout_no_bits", bits_seen - b0, 0);
    check("stuck_low_idle", busy, 0);
    #1 nget = 1'b1;
    repeat (6) @(posedge clk);

    b0 = bits_seen; o0 = ovr_seen;
    start_frame(8'hA5, 8'hA5, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (bits_seen > b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("overrun_first_bit", ok, 1);
    repeat (2) @(posedge clk); #1 nget = 1'b0;
    repeat (3) @(posedge clk); #1 nget = 1'b1;
    finish_frame("overrun_a5", b0);
    repeat (20) @(negedge clk); #1;
    check("overrun_pulse_count", ovr_seen - o0, 1);
    check("overrun_no_second_frame", bits_seen - b0, FRAME_LEN);
    check("overrun_idle", busy, 0);

    b0 = bits_seen;
    start_frame(8'h99, 8'h99, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (bits_seen - b0 >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    check("reset_reached_bit4", ok, 1);
    rst = 1'b1;
    #1;
    check("midreset_dena", dena, 0);
    check("midreset_dout", dout, 0);
    check("midreset_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(posedge clk); #1 rst = 1'b0;
    b1 = bits_seen;
    repeat (30) @(negedge clk); #1;
    check("postreset_no_bits", bits_seen - b1, 0);
    check("postreset_idle", busy, 0);

    b0 = bits_seen; start_frame(8'h99, 8'h99, 1'b0); finish_frame("postreset_99", b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
